// File: rtl/jtopl_pkg.sv
// Shared OPL constants: register group bases, update-strobe indices and the default hold length.
package jtopl_pkg;

    localparam int SLOTS_DEF = 18;

    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_MULT  = 8'h20;
    localparam logic [7:0] REG_KSLTL = 8'h40;
    localparam logic [7:0] REG_ARDR  = 8'h60;
    localparam logic [7:0] REG_SLRR  = 8'h80;
    localparam logic [7:0] REG_FNLO  = 8'hA0;
    localparam logic [7:0] REG_FNHI  = 8'hB0;
    localparam logic [7:0] REG_FBCON = 8'hC0;
    localparam logic [7:0] REG_WAV   = 8'hE0;
    localparam logic [7:0] REG_RHY   = 8'hBD;

    typedef enum logic [2:0] {
        STB_FBCON = 3'd0,
        STB_FNLO  = 3'd1,
        STB_FNHI  = 3'd2,
        STB_MULT  = 3'd3,
        STB_KSLTL = 3'd4,
        STB_ARDR  = 3'd5,
        STB_SLRR  = 3'd6,
        STB_WAV   = 3'd7
    } stb_e;

    localparam int NSTB = 8;

endpackage

// File: rtl/jtopl_mmr_wr_if.sv
// CPU write bus of the OPL: 8-bit data, address/data port select, active-low chip select and write strobe.
// Handshake: a bus cycle is the interval where cpu_cs_n and cpu_wr_n are both low; the slave takes
// cpu_addr/cpu_din on the clk that sees that interval end, so both must stay valid until then.
interface jtopl_mmr_wr_if;
    logic [7:0] cpu_din;
    logic       cpu_addr;
    logic       cpu_cs_n;
    logic       cpu_wr_n;

    modport master (output cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n);
    modport slave  (input  cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n);
endinterface

// File: rtl/jtopl_mmr_dec.sv
// Combinational OPL register address decoder: operator/channel register -> group, subslot, one-hot strobe.
module jtopl_mmr_dec
    import jtopl_pkg::*;
#(
    parameter bit WAV_EN = 1'b0
) (
    input  logic [7:0]      addr,
    output logic            mapped,
    output logic [1:0]      group,
    output logic [2:0]      sub,
    output logic [NSTB-1:0] stb
);

    stb_e       op_idx, ch_idx, idx;
    logic       op_hit, ch_hit, op_ok, ch_ok;
    logic [4:0] op_off;
    logic [3:0] ch_n;
    logic [1:0] ch_group;
    logic [2:0] ch_sub;

    always_comb begin
        op_off = addr[4:0];
        ch_n   = addr[3:0];
        // Offsets 6,7 within each 8-block and the whole 0x18-0x1F tail have no operator behind them
        op_ok  = (op_off[4:3] != 2'd3) && (op_off[2:0] < 3'd6);
        ch_ok  = (ch_n < 4'd9);

        op_hit = 1'b1;
        op_idx = STB_MULT;
        case ({addr[7:5], 5'd0})
            REG_MULT:  op_idx = STB_MULT;
            REG_KSLTL: op_idx = STB_KSLTL;
            REG_ARDR:  op_idx = STB_ARDR;
            REG_SLRR:  op_idx = STB_SLRR;
            REG_WAV: begin
                op_idx = STB_WAV;
                op_hit = WAV_EN;
            end
            default:   op_hit = 1'b0;
        endcase

        ch_hit = 1'b1;
        ch_idx = STB_FNLO;
        case ({addr[7:4], 4'd0})
            REG_FNLO:  ch_idx = STB_FNLO;
            REG_FNHI:  ch_idx = STB_FNHI;
            REG_FBCON: ch_idx = STB_FBCON;
            default:   ch_hit = 1'b0;
        endcase

        case (ch_n)
            4'd0:    begin ch_group = 2'd0; ch_sub = 3'd0; end
            4'd1:    begin ch_group = 2'd0; ch_sub = 3'd1; end
            4'd2:    begin ch_group = 2'd0; ch_sub = 3'd2; end
            4'd3:    begin ch_group = 2'd1; ch_sub = 3'd0; end
            4'd4:    begin ch_group = 2'd1; ch_sub = 3'd1; end
            4'd5:    begin ch_group = 2'd1; ch_sub = 3'd2; end
            4'd6:    begin ch_group = 2'd2; ch_sub = 3'd0; end
            4'd7:    begin ch_group = 2'd2; ch_sub = 3'd1; end
            4'd8:    begin ch_group = 2'd2; ch_sub = 3'd2; end
            default: begin ch_group = 2'd0; ch_sub = 3'd0; end
        endcase

        mapped = 1'b0;
        group  = 2'd0;
        sub    = 3'd0;
        idx    = STB_FBCON;
        if (op_hit && op_ok) begin
            mapped = 1'b1;
            group  = op_off[4:3];
            sub    = op_off[2:0];
            idx    = op_idx;
        end else if (ch_hit && ch_ok) begin
            mapped = 1'b1;
            group  = ch_group;
            sub    = ch_sub;
            idx    = ch_idx;
        end

        stb = mapped ? ({{(NSTB-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/jtopl_mmr_wr.sv
// OPL CPU write front-end: bus capture, request hold for one slot sweep, global regs 0x01/0xBD.
// Build option JTOPL_WAVSEL_EN (with OPL_TYPE>1) enables wave-select registers 0xE0-0xF5 and WSE.
module jtopl_mmr_wr
    import jtopl_pkg::*;
#(
    parameter int SLOTS    = SLOTS_DEF,
    parameter int OPL_TYPE = 1
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    jtopl_mmr_wr_if.slave   cpu,
    output logic            busy,
    output logic            overrun,
    output logic [7:0]      din,
    output logic            write,
    output logic [1:0]      sel_group,
    output logic [2:0]      sel_sub,
    output logic            up_fbcon,
    output logic            up_fnumlo,
    output logic            up_fnumhi,
    output logic            up_mult,
    output logic            up_ksl_tl,
    output logic            up_ar_dr,
    output logic            up_sl_rr,
    output logic            up_wav,
    output logic            rhy_en,
    output logic [4:0]      rhy_kon,
    output logic            am_dep,
    output logic            vib_dep,
    output logic            wave_mode
);

`ifdef JTOPL_WAVSEL_EN
    localparam bit WAVSEL_BUILD = 1'b1;
`else
    localparam bit WAVSEL_BUILD = 1'b0;
`endif
    localparam bit WAV_EN = WAVSEL_BUILD && (OPL_TYPE > 1);
    localparam int CW     = $clog2(SLOTS + 1);

    logic            wr_act, wr_act_q, accept;
    logic [7:0]      addr_q;
    logic [CW-1:0]   cnt;
    logic [NSTB-1:0] stb_q;
    logic            last_tick, free;
    logic            dec_mapped;
    logic [1:0]      dec_group;
    logic [2:0]      dec_sub;
    logic [NSTB-1:0] dec_stb;

    jtopl_mmr_dec #(.WAV_EN(WAV_EN)) u_dec (
        .addr   (addr_q),
        .mapped (dec_mapped),
        .group  (dec_group),
        .sub    (dec_sub),
        .stb    (dec_stb)
    );

    // A bus cycle is taken when it ends, so one long strobe still yields a single accept
    assign wr_act    = !cpu.cpu_cs_n && !cpu.cpu_wr_n;
    assign accept    = wr_act_q && !wr_act;
    // The sweep's last tick frees the slot in the same clk a new request may claim it
    assign last_tick = busy && cen && (cnt == CW'(1));
    assign free      = !busy || last_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_act_q  <= 1'b0;
            addr_q    <= 8'h00;
            cnt       <= '0;
            stb_q     <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            din       <= 8'h00;
            write     <= 1'b0;
            sel_group <= 2'd0;
            sel_sub   <= 3'd0;
            rhy_en    <= 1'b0;
            rhy_kon   <= 5'd0;
            am_dep    <= 1'b0;
            vib_dep   <= 1'b0;
            wave_mode <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            write    <= 1'b0;

            if (busy && cen) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    stb_q <= '0;
                end
            end

            if (accept && !cpu.cpu_addr) begin
                addr_q <= cpu.cpu_din;
            end

            if (accept && cpu.cpu_addr) begin
                if (dec_mapped) begin
                    if (free) begin
                        write     <= 1'b1;
                        din       <= cpu.cpu_din;
                        sel_group <= dec_group;
                        sel_sub   <= dec_sub;
                        stb_q     <= dec_stb;
                        busy      <= 1'b1;
                        cnt       <= CW'(SLOTS);
                    end else begin
                        overrun   <= 1'b1;
                    end
                end else begin
                    write <= 1'b1;
                    if (addr_q == REG_RHY) begin
                        {am_dep, vib_dep, rhy_en, rhy_kon} <= cpu.cpu_din;
                    end
                    if (WAV_EN && (addr_q == REG_TEST)) begin
                        wave_mode <= cpu.cpu_din[5];
                    end
                end
            end
        end
    end

    assign up_fbcon  = stb_q[STB_FBCON];
    assign up_fnumlo = stb_q[STB_FNLO];
    assign up_fnumhi = stb_q[STB_FNHI];
    assign up_mult   = stb_q[STB_MULT];
    assign up_ksl_tl = stb_q[STB_KSLTL];
    assign up_ar_dr  = stb_q[STB_ARDR];
    assign up_sl_rr  = stb_q[STB_SLRR];
    assign up_wav    = stb_q[STB_WAV];

endmodule

// File: tb/tb_jtopl_mmr_wr.sv
// Bench for jtopl_mmr_wr: decode table with scoreboard, then overrun, 0xBD, reset-abort,
// back-to-back and wave-select sequences.
module tb_jtopl_mmr_wr;
  localparam int SLOTS = 18;
  localparam int W = 24;

  // bench strobe order: 0 fnumlo, 1 fnumhi, 2 fbcon, 3 mult, 4 ksl_tl, 5 ar_dr, 6 sl_rr, 7 wav
  localparam logic [7:0] S_FNLO = 8'h01, S_FNHI = 8'h02, S_FBCON = 8'h04, S_MULT = 8'h08,
                         S_KSLTL = 8'h10, S_ARDR = 8'h20, S_SLRR = 8'h40, S_WAV = 8'h80;

  logic clk = 1'b0;
  logic rst, cen;
  logic busy, overrun, write, rhy_en, am_dep, vib_dep, wave_mode;
  logic up_fbcon, up_fnumlo, up_fnumhi, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
  logic [7:0] din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic [4:0] rhy_kon;

  jtopl_mmr_wr_if cpu();

  jtopl_mmr_wr #(.SLOTS(SLOTS), .OPL_TYPE(2)) dut (
    .rst(rst), .clk(clk), .cen(cen), .cpu(cpu),
    .busy(busy), .overrun(overrun), .din(din), .write(write),
    .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fbcon(up_fbcon), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_mult(up_mult),
    .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr), .up_wav(up_wav),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon), .am_dep(am_dep), .vib_dep(vib_dep), .wave_mode(wave_mode)
  );

  // clock / reset / cen
  initial forever #5 clk = ~clk;

  logic cen_rand = 1'b1;
  logic cen_man = 1'b0;
  int cen_ticks = 0;

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      cen = cen_rand ? 1'($urandom_range(0, 1)) : cen_man;
    end
  end

  initial forever begin
    @(posedge clk);
    if (cen) cen_ticks++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obs_stb();
    return {up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult, up_fbcon, up_fnumhi, up_fnumlo};
  endfunction

  // driver: one bus cycle; optionally a cen tick lands on the accepting clk
  task automatic cpu_wr(input logic a, input logic [7:0] d, input bit cen_last = 1'b0);
    @(negedge clk);
    cpu.cpu_din = d;
    cpu.cpu_addr = a;
    cpu.cpu_cs_n = 1'b0;
    cpu.cpu_wr_n = 1'b0;
    @(posedge clk);
    #1;
    if (cen_last) cen_man = 1'b1;
    @(negedge clk);
    cpu.cpu_cs_n = 1'b1;
    cpu.cpu_wr_n = 1'b1;
    @(posedge clk);
    #1;
    cen_man = 1'b0;
  endtask

  task automatic cen_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      cen_man = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      cen_man = 1'b0;
    end
  endtask

  task automatic hold_check(input int start);
    int k;
    k = 0;
    while (obs_stb() != 8'h00 && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("hold_done", 32'(obs_stb() == 8'h00), 32'd1);
    if (obs_stb() == 8'h00) chk("hold_ticks", cen_ticks - start, SLOTS);
    chk("busy_clr", busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       mapped;
    logic [7:0] stb;
    logic [1:0] grp;
    logic [2:0] sub;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [W-1:0] e, act;
    int start, k;

    tbl[0]  = '{8'h33, 8'h5A, 1'b1, S_MULT,  2'd2, 3'd3};
    tbl[1]  = '{8'h93, 8'hC3, 1'b1, S_SLRR,  2'd2, 3'd3};
    tbl[2]  = '{8'hA7, 8'h44, 1'b1, S_FNLO,  2'd2, 3'd1};
    tbl[3]  = '{8'h26, 8'h11, 1'b0, 8'h00,   2'd0, 3'd0};
    tbl[4]  = '{8'hA9, 8'h22, 1'b0, 8'h00,   2'd0, 3'd0};
    tbl[5]  = '{8'h00, 8'h33, 1'b0, 8'h00,   2'd0, 3'd0};
    tbl[6]  = '{8'h40, 8'h01, 1'b1, S_KSLTL, 2'd0, 3'd0};
    tbl[7]  = '{8'h75, 8'h7E, 1'b1, S_ARDR,  2'd2, 3'd5};
    tbl[8]  = '{8'hB0, 8'h99, 1'b1, S_FNHI,  2'd0, 3'd0};
    tbl[9]  = '{8'hC8, 8'h0F, 1'b1, S_FBCON, 2'd2, 3'd2};
    tbl[10] = '{8'h36, 8'h10, 1'b0, 8'h00,   2'd0, 3'd0};
    tbl[11] = '{8'h2E, 8'h20, 1'b0, 8'h00,   2'd0, 3'd0};
`ifdef JTOPL_WAVSEL_EN
    tbl[12] = '{8'hE8, 8'h03, 1'b1, S_WAV,   2'd1, 3'd0};
`else
    tbl[12] = '{8'hE8, 8'h03, 1'b0, 8'h00,   2'd0, 3'd0};
`endif
    tbl[13] = '{8'h65, 8'h12, 1'b1, S_ARDR,  2'd0, 3'd5};

    // reset
    rst = 1'b1;
    cpu.cpu_din = 8'h00;
    cpu.cpu_addr = 1'b0;
    cpu.cpu_cs_n = 1'b1;
    cpu.cpu_wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, overrun, write, obs_stb(), sel_group, sel_sub, din}, 32'd0);
    chk("rst_glob", {am_dep, vib_dep, rhy_en, rhy_kon, wave_mode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // decode table
    foreach (tbl[i]) begin
      cpu_wr(1'b0, tbl[i].addr);
      exp_q.push_back({tbl[i].mapped, 1'b1, tbl[i].mapped, tbl[i].stb, tbl[i].grp, tbl[i].sub, tbl[i].data});
      cpu_wr(1'b1, tbl[i].data);
      start = cen_ticks;
      e = exp_q.pop_front();
      act = {e[23], write, busy, obs_stb(), sel_group, sel_sub, din};
      if (e[23]) chk($sformatf("vec%0d", i), act, e);
      else chk($sformatf("vec%0d", i), act[22:13], e[22:13]);
      @(posedge clk);
      #1;
      chk("write_pulse", write, 1'b0);
      if (e[23]) hold_check(start);
    end
    chk("q_empty", exp_q.size(), 0);

    // overrun while busy, address latch still taken, 0xBD not dropped
    cpu_wr(1'b0, 8'h93);
    cpu_wr(1'b1, 8'h5A);
    start = cen_ticks;
    chk("ov_req", {busy, obs_stb()}, {1'b1, S_SLRR});
    cpu_wr(1'b0, 8'h40);
    cpu_wr(1'b1, 8'h77);
    chk("ov_drop", {write, overrun, busy, obs_stb(), sel_group, sel_sub, din},
        {1'b0, 1'b1, 1'b1, S_SLRR, 2'd2, 3'd3, 8'h5A});
    cpu_wr(1'b0, 8'hBD);
    cpu_wr(1'b1, 8'h3F);
    chk("rhy_busy", {write, busy, am_dep, vib_dep, rhy_en, rhy_kon}, {1'b1, 1'b1, 8'h3F});
    chk("rhy_keep", {obs_stb(), din}, {S_SLRR, 8'h5A});
    hold_check(start);
    chk("ov_sticky", overrun, 1'b1);

    // reset in the middle of a hold
    cpu_wr(1'b0, 8'h4A);
    cpu_wr(1'b1, 8'h21);
    start = cen_ticks;
    chk("mid_req", {obs_stb(), sel_group, sel_sub}, {S_KSLTL, 2'd1, 3'd2});
    k = 0;
    while ((cen_ticks - start) < 9 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("mid_reach9", 32'((cen_ticks - start) >= 9), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst", {busy, overrun, write, obs_stb(), am_dep, vib_dep, rhy_en, rhy_kon}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_wr(1'b1, 8'h55);
    chk("rst_addr0", {write, busy, obs_stb()}, {1'b1, 1'b0, 8'h00});
    cpu_wr(1'b0, 8'hB4);
    cpu_wr(1'b1, 8'h66);
    start = cen_ticks;
    chk("post_rst", {write, busy, obs_stb(), sel_group, sel_sub, din},
        {1'b1, 1'b1, S_FNHI, 2'd1, 3'd1, 8'h66});
    hold_check(start);

    // back-to-back: new request accepted on the final cen tick
    cen_rand = 1'b0;
    cen_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_wr(1'b0, 8'h2D);
    cpu_wr(1'b1, 8'hA1);
    chk("b2b_first", {busy, obs_stb(), sel_group, sel_sub}, {1'b1, S_MULT, 2'd1, 3'd5});
    cpu_wr(1'b0, 8'hC5);
    cen_pulse(SLOTS - 1);
    chk("b2b_pre", {busy, obs_stb()}, {1'b1, S_MULT});
    cpu_wr(1'b1, 8'hB2, 1'b1);
    chk("b2b_load", {write, busy, overrun, obs_stb(), sel_group, sel_sub, din},
        {1'b1, 1'b1, 1'b0, S_FBCON, 2'd1, 3'd2, 8'hB2});
    cen_pulse(SLOTS - 1);
    chk("b2b_hold", {busy, obs_stb()}, {1'b1, S_FBCON});
    cen_pulse(1);
    chk("b2b_end", {busy, obs_stb()}, {1'b0, 8'h00});
    cen_rand = 1'b1;

    // wave select enable register
    cpu_wr(1'b0, 8'h01);
    cpu_wr(1'b1, 8'h20);
`ifdef JTOPL_WAVSEL_EN
    chk("wse_set", {write, busy, wave_mode}, {1'b1, 1'b0, 1'b1});
`else
    chk("wse_set", {write, busy, wave_mode}, {1'b1, 1'b0, 1'b0});
`endif
    cpu_wr(1'b1, 8'h00);
    chk("wse_clr", {write, wave_mode}, {1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
